rv_fetch_unit: RTL and testbench

Instruction fetch stage of the uRV pipeline; sits directly upstream of the predecode stage.
- Owns the program counter.
- Drives the synchronous instruction memory port.
- Presents the fetched word and its PC, together with a fetch-stall indication, to predecode.
- Handles execute-stage stalls, branch/jump redirects and misaligned-target faults.

---
 rtl/rv_fetch_unit_if.sv | 22 ++
 rtl/rv_fetch_unit.sv | 124 ++++++++++++
 tb/tb_rv_fetch_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_unit_if.sv
// Synchronous instruction-memory port between the fetch unit (master) and the memory (slave).
// Data and valid answer the address that was presented with a read request in the previous cycle.
interface rv_fetch_unit_if;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i;
  logic        im_valid_i;

  modport master (
    output im_addr_o,
    output im_rd_o,
    input  im_data_i,
    input  im_valid_i
  );

  modport slave (
    input  im_addr_o,
    input  im_rd_o,
    output im_data_i,
    output im_valid_i
  );
endinterface

// File: rtl/rv_fetch_unit.sv
// uRV instruction fetch stage: owns the PC, drives the synchronous instruction memory and
// hands the fetched word plus its PC to predecode, handling stalls, redirects and misaligned targets.
module rv_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  rv_fetch_unit_if.master         im,
  input  logic                    x_stall_i,
  input  logic                    x_bra_i,
  input  logic [31:0]             x_pc_bra_i,
  output logic [31:0]             f_ir_o,
  output logic [31:0]             f_pc_o,
  output logic                    f_valid_o,
  output logic                    f_stall_o,
  output logic                    f_fault_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_req_q, pc_req_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] im_addr;
  logic        im_rd;
  logic        stall;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can leave it unassigned and infer a latch.
    state_d  = state_q;
    pc_req_d = pc_req_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    im_addr  = pc_req_q;
    im_rd    = 1'b0;
    stall    = 1'b1;

    if (!rst_i) begin
      unique case (state_q)
        ST_BOOT: begin
          im_rd   = 1'b1;
          state_d = ST_RUN;
        end

        ST_RUN: begin
          // A redirect beats a stall: the word on im_data_i belongs to the wrong path anyway.
          if (x_bra_i) begin
            valid_d = 1'b0;
            if (x_pc_bra_i[1:0] == 2'b00) begin
              im_addr  = x_pc_bra_i;
              im_rd    = 1'b1;
              pc_req_d = x_pc_bra_i;
            end else begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end
          end else if (x_stall_i) begin
            // Re-read pc_req so the same word is still on im_data_i when the stall lifts.
            im_rd = 1'b1;
          end else if (!im.im_valid_i) begin
            im_rd   = 1'b1;
            valid_d = 1'b0;
          end else begin
            ir_d     = im.im_data_i;
            pc_d     = pc_req_q;
            valid_d  = 1'b1;
            pc_req_d = pc_req_q + 32'd4;
            im_addr  = pc_req_q + 32'd4;
            im_rd    = 1'b1;
            stall    = 1'b0;
          end
        end

        ST_FAULT: begin
          valid_d = 1'b0;
        end

        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst_i) begin
      state_q  <= ST_BOOT;
      pc_req_q <= RESET_VECTOR;
      ir_q     <= NOP;
      pc_q     <= RESET_VECTOR;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_req_q <= pc_req_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  assign im.im_addr_o = im_addr;
  assign im.im_rd_o   = im_rd;
  assign f_ir_o       = ir_q;
  assign f_pc_o       = pc_q;
  assign f_valid_o    = valid_q;
  assign f_stall_o    = stall;
  assign f_fault_o    = fault_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: boot, stall, redirect, stall-vs-redirect priority,
// misaligned fault with reset recovery, wait states and PC wrap-around.
module tb_rv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        x_stall_i;
  logic        x_bra_i;
  logic [31:0] x_pc_bra_i;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_valid_o;
  logic        f_stall_o;
  logic        f_fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  rv_fetch_unit_if im_if ();

  // Memory model: registered read, data word is the bitwise inverse of its address.
  logic [31:0] mem_addr_q = '0;
  logic        mem_rd_q   = 1'b0;
  logic        mem_ok;

  always @(posedge clk) begin
    mem_addr_q <= im_if.im_addr_o;
    mem_rd_q   <= im_if.im_rd_o;
  end

  assign im_if.im_data_i  = ~mem_addr_q;
  assign im_if.im_valid_i = mem_rd_q & mem_ok;

  rv_fetch_unit #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .im         (im_if.master),
    .x_stall_i  (x_stall_i),
    .x_bra_i    (x_bra_i),
    .x_pc_bra_i (x_pc_bra_i),
    .f_ir_o     (f_ir_o),
    .f_pc_o     (f_pc_o),
    .f_valid_o  (f_valid_o),
    .f_stall_o  (f_stall_o),
    .f_fault_o  (f_fault_o)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i      = 1'b1;
    x_stall_i  = 1'b0;
    x_bra_i    = 1'b0;
    x_pc_bra_i = '0;
    mem_ok     = 1'b1;

    // Reset state
    cyc();
    cyc();
    check1 ("rst_im_rd",   im_if.im_rd_o, 1'b0);
    check1 ("rst_stall",   f_stall_o,     1'b1);
    check1 ("rst_valid",   f_valid_o,     1'b0);
    check32("rst_ir",      f_ir_o,        32'h0000_0013);
    check32("rst_pc",      f_pc_o,        32'h0000_0100);
    check1 ("rst_fault",   f_fault_o,     1'b0);

    // Boot: first request in the cycle after reset falls
    rst_i = 1'b0;
    #1;
    check1 ("boot_rd",     im_if.im_rd_o,   1'b1);
    check32("boot_addr",   im_if.im_addr_o, 32'h0000_0100);
    check1 ("boot_stall",  f_stall_o,       1'b1);
    cyc();
    check32("run1_addr",   im_if.im_addr_o, 32'h0000_0104);
    check1 ("run1_stall",  f_stall_o,       1'b0);
    check1 ("run1_valid",  f_valid_o,       1'b0);
    cyc();
    check1 ("first_valid", f_valid_o,       1'b1);
    check32("first_pc",    f_pc_o,          32'h0000_0100);
    check32("first_ir",    f_ir_o,          ~32'h0000_0100);
    check32("run2_addr",   im_if.im_addr_o, 32'h0000_0108);
    cyc();
    check32("second_pc",   f_pc_o,          32'h0000_0104);
    check32("run3_addr",   im_if.im_addr_o, 32'h0000_010C);

    // Execute stall for three cycles
    x_stall_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check32("stall_addr",  im_if.im_addr_o, 32'h0000_0108);
      check1 ("stall_stall", f_stall_o,       1'b1);
      check32("stall_pc",    f_pc_o,          32'h0000_0104);
      check1 ("stall_valid", f_valid_o,       1'b1);
      check32("stall_ir",    f_ir_o,          ~32'h0000_0104);
      if (i < 2) cyc();
    end
    cyc();
    x_stall_i = 1'b0;
    #1;
    check32("unstall_addr",  im_if.im_addr_o, 32'h0000_010C);
    check1 ("unstall_stall", f_stall_o,       1'b0);
    check32("unstall_pc",    f_pc_o,          32'h0000_0104);
    cyc();
    check32("post_stall_pc", f_pc_o,          32'h0000_0108);
    check32("post_stall_ir", f_ir_o,          ~32'h0000_0108);

    // Redirect to 0x2000 while fetching 0x10C
    x_bra_i    = 1'b1;
    x_pc_bra_i = 32'h0000_2000;
    #1;
    check32("bra_addr",      im_if.im_addr_o, 32'h0000_2000);
    check1 ("bra_rd",        im_if.im_rd_o,   1'b1);
    check1 ("bra_stall",     f_stall_o,       1'b1);
    cyc();
    x_bra_i = 1'b0;
    #1;
    check1 ("bra_bubble",    f_valid_o,       1'b0);
    check32("bra_next_addr", im_if.im_addr_o, 32'h0000_2004);
    cyc();
    check1 ("bra_tgt_valid", f_valid_o,       1'b1);
    check32("bra_tgt_pc",    f_pc_o,          32'h0000_2000);
    check32("bra_tgt_ir",    f_ir_o,          ~32'h0000_2000);

    // Redirect and stall together: redirect wins
    x_bra_i    = 1'b1;
    x_stall_i  = 1'b1;
    x_pc_bra_i = 32'h0000_0040;
    #1;
    check32("prio_addr",     im_if.im_addr_o, 32'h0000_0040);
    check1 ("prio_rd",       im_if.im_rd_o,   1'b1);
    cyc();
    x_bra_i   = 1'b0;
    x_stall_i = 1'b0;
    #1;
    check1 ("prio_valid",    f_valid_o,       1'b0);
    check32("prio_pcreq",    im_if.im_addr_o, 32'h0000_0044);
    cyc();
    check32("prio_tgt_pc",   f_pc_o,          32'h0000_0040);
    check32("prio_tgt_ir",   f_ir_o,          ~32'h0000_0040);

    // Misaligned target: sticky fault, branches ignored, reset recovers
    x_bra_i    = 1'b1;
    x_pc_bra_i = 32'h0000_2002;
    #1;
    check1 ("mis_rd",        im_if.im_rd_o,   1'b0);
    check1 ("mis_stall",     f_stall_o,       1'b1);
    cyc();
    check1 ("fault_set",     f_fault_o,       1'b1);
    check1 ("fault_valid",   f_valid_o,       1'b0);
    x_pc_bra_i = 32'h0000_3000;
    #1;
    check1 ("fault_bra_rd",  im_if.im_rd_o,   1'b0);
    cyc();
    check1 ("fault_sticky",  f_fault_o,       1'b1);
    check1 ("fault_valid2",  f_valid_o,       1'b0);
    check1 ("fault_stall",   f_stall_o,       1'b1);
    x_bra_i = 1'b0;
    rst_i   = 1'b1;
    cyc();
    check1 ("rec_fault",     f_fault_o,       1'b0);
    check32("rec_pc",        f_pc_o,          32'h0000_0100);
    check1 ("rec_valid",     f_valid_o,       1'b0);
    check1 ("rec_rd",        im_if.im_rd_o,   1'b0);
    rst_i = 1'b0;
    #1;
    check32("rec_boot_addr", im_if.im_addr_o, 32'h0000_0100);
    check1 ("rec_boot_rd",   im_if.im_rd_o,   1'b1);
    cyc();
    check32("rec_run_addr",  im_if.im_addr_o, 32'h0000_0104);
    cyc();
    check32("rec_first_pc",  f_pc_o,          32'h0000_0100);
    check1 ("rec_first_vld", f_valid_o,       1'b1);

    // Branch to the top word, two wait states, then wrap to zero
    x_bra_i    = 1'b1;
    x_pc_bra_i = 32'hFFFF_FFFC;
    #1;
    check32("wrap_bra_addr", im_if.im_addr_o, 32'hFFFF_FFFC);
    cyc();
    x_bra_i = 1'b0;
    mem_ok  = 1'b0;
    #1;
    check32("wait1_addr",    im_if.im_addr_o, 32'hFFFF_FFFC);
    check1 ("wait1_rd",      im_if.im_rd_o,   1'b1);
    check1 ("wait1_valid",   f_valid_o,       1'b0);
    check1 ("wait1_stall",   f_stall_o,       1'b1);
    cyc();
    check32("wait2_addr",    im_if.im_addr_o, 32'hFFFF_FFFC);
    check1 ("wait2_valid",   f_valid_o,       1'b0);
    cyc();
    check1 ("wait_hold_vld", f_valid_o,       1'b0);
    mem_ok = 1'b1;
    #1;
    check32("wrap_addr",     im_if.im_addr_o, 32'h0000_0000);
    check1 ("wrap_stall",    f_stall_o,       1'b0);
    cyc();
    check32("top_pc",        f_pc_o,          32'hFFFF_FFFC);
    check32("top_ir",        f_ir_o,          32'h0000_0003);
    check1 ("top_valid",     f_valid_o,       1'b1);
    check32("after_wrap_addr", im_if.im_addr_o, 32'h0000_0004);
    cyc();
    check32("zero_pc",       f_pc_o,          32'h0000_0000);
    check32("zero_ir",       f_ir_o,          32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
